// File: rtl/gpio_edge_capture_pkg.sv
// Shared constants for the GPIO edge-capture peripheral: register word
// offsets (address bits [4:2]) and the debounce agreement counter width.
package gpio_edge_capture_pkg;

  localparam int unsigned DEB_CNT_W = 4;
  localparam int unsigned REG_IDX_W = 3;

  localparam logic [REG_IDX_W-1:0] GPIO_IN       = 3'd0;
  localparam logic [REG_IDX_W-1:0] GPIO_RISE_EN  = 3'd1;
  localparam logic [REG_IDX_W-1:0] GPIO_FALL_EN  = 3'd2;
  localparam logic [REG_IDX_W-1:0] GPIO_PENDING  = 3'd3;
  localparam logic [REG_IDX_W-1:0] GPIO_EVCOUNT  = 3'd4;
  localparam logic [REG_IDX_W-1:0] GPIO_DEBOUNCE = 3'd5;

endpackage

// File: rtl/gpio_edge_capture_debounce_bit.sv
// One GPIO input bit: 2-flop synchroniser followed by a tick-driven
// agreement counter that flips the debounced level after DEB_COUNT ticks.
module gpio_debounce_bit
  import gpio_edge_capture_pkg::*;
#(
  parameter int unsigned DEB_COUNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_deb
);

  logic                 r_sync0;
  logic                 r_sync1;
  logic                 r_deb;
  logic [DEB_CNT_W-1:0] r_cnt;
  logic [DEB_CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + DEB_CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
      // Counter only moves on ticks; reaching the threshold flips and clears.
      if (i_tick) begin
        if (r_sync1 == r_deb) begin
          r_cnt <= '0;
        end else if (w_cnt_inc == DEB_CNT_W'(DEB_COUNT)) begin
          r_deb <= ~r_deb;
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/gpio_edge_capture.sv
// Wishbone GPIO input block: debounced inputs, masked edge detection,
// W1C pending register, 16-bit event counter and level interrupt.
module gpio_edge_capture
  import gpio_edge_capture_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEB_COUNT      = 3,
  parameter int unsigned PRESCALE_RESET = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             intr_o
);

  logic [WIDTH-1:0]     w_deb;
  logic [WIDTH-1:0]     r_deb_prev;
  logic [WIDTH-1:0]     r_rise;
  logic [WIDTH-1:0]     r_fall;
  logic [WIDTH-1:0]     r_rise_en;
  logic [WIDTH-1:0]     r_fall_en;
  logic [WIDTH-1:0]     r_pending;
  logic [WIDTH-1:0]     w_ev;
  logic [WIDTH-1:0]     w_clr;
  logic [15:0]          r_evcount;
  logic [15:0]          r_prescale;
  logic [15:0]          r_pcnt;
  logic                 w_tick;
  logic                 w_acc;
  logic                 w_wr;
  logic [REG_IDX_W-1:0] w_idx;
  logic [31:0]          w_rdata;
  logic                 w_unused;

  assign w_acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign w_wr  = w_acc & wb_we_i;
  assign w_idx = wb_adr_i[4:2];
  assign w_unused = &{1'b0, wb_adr_i, wb_sel_i, wb_dat_i};

  // Shared debounce sample tick.
  assign w_tick = (r_pcnt == r_prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prescale <= 16'(PRESCALE_RESET);
      r_pcnt     <= '0;
    end else if (w_wr && w_idx == GPIO_DEBOUNCE) begin
      r_prescale <= wb_dat_i[15:0];
      r_pcnt     <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
    gpio_debounce_bit #(
      .DEB_COUNT(DEB_COUNT)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .i_raw (gpio_i[g]),
      .i_tick(w_tick),
      .o_deb (w_deb[g])
    );
  end

  assign w_ev  = (r_rise & r_rise_en) | (r_fall & r_fall_en);
  assign w_clr = (w_wr && w_idx == GPIO_PENDING) ? wb_dat_i[WIDTH-1:0] : '0;

  // Edge detect, event latching and counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_prev <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_pending  <= '0;
      r_evcount  <= '0;
      intr_o     <= 1'b0;
    end else begin
      r_deb_prev <= w_deb;
      r_rise     <= w_deb & ~r_deb_prev;
      r_fall     <= ~w_deb & r_deb_prev;
      r_pending  <= (r_pending & ~w_clr) | w_ev;
      intr_o     <= |r_pending;
      if (w_wr && w_idx == GPIO_RISE_EN) r_rise_en <= wb_dat_i[WIDTH-1:0];
      if (w_wr && w_idx == GPIO_FALL_EN) r_fall_en <= wb_dat_i[WIDTH-1:0];
      if (w_wr && w_idx == GPIO_EVCOUNT) begin
        r_evcount <= wb_dat_i[15:0];
      end else if (|w_ev) begin
        r_evcount <= r_evcount + 16'd1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      GPIO_IN:       w_rdata = 32'(w_deb);
      GPIO_RISE_EN:  w_rdata = 32'(r_rise_en);
      GPIO_FALL_EN:  w_rdata = 32'(r_fall_en);
      GPIO_PENDING:  w_rdata = 32'(r_pending);
      GPIO_EVCOUNT:  w_rdata = 32'(r_evcount);
      GPIO_DEBOUNCE: w_rdata = 32'(r_prescale);
      default:       w_rdata = '0;
    endcase
  end

  // Single-cycle ack; read data captured with the access and held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= w_acc;
      if (w_acc) wb_dat_o <= w_rdata;
    end
  end

endmodule

// File: tb/tb_gpio_edge_capture.sv
// Directed bench for gpio_edge_capture with hand-computed expectations.
module tb_gpio_edge_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gpio;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack, intr;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] A_IN = 32'h00, A_RISE = 32'h04, A_FALL = 32'h08, A_PEND = 32'h0C;
  localparam logic [31:0] A_EVC = 32'h10, A_DEB = 32'h14, A_R18 = 32'h18, A_R1C = 32'h1C;

  gpio_edge_capture #(.WIDTH(8), .DEB_COUNT(3), .PRESCALE_RESET(99)) dut (
    .clk     (clk),
    .rst     (rst),
    .gpio_i  (gpio),
    .wb_cyc_i(wb_cyc),
    .wb_stb_i(wb_stb),
    .wb_we_i (wb_we),
    .wb_adr_i(wb_adr),
    .wb_sel_i(wb_sel),
    .wb_dat_i(wb_dat_w),
    .wb_dat_o(wb_dat_r),
    .wb_ack_o(wb_ack),
    .intr_o  (intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat_w = dat;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check("wr_ack", 32'(wb_ack), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = adr;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check("rd_ack", 32'(wb_ack), 32'd1);
    check(tag, wb_dat_r, exp);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; gpio = '0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat_w = '0; wb_sel = 4'hF;
    #72;
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_dat", wb_dat_r, 32'd0);
    check("rst_intr", 32'(intr), 32'd0);
    #8 rst = 1'b1;
    idle(1);

    // Register reset values.
    rd_check("rst_in", A_IN, 32'h0);
    rd_check("rst_rise", A_RISE, 32'h0);
    rd_check("rst_fall", A_FALL, 32'h0);
    rd_check("rst_pend", A_PEND, 32'h0);
    rd_check("rst_evc", A_EVC, 32'h0);
    rd_check("rst_deb", A_DEB, 32'd99);

    // Rising edge with exact latency: PENDING at edge 7, intr at edge 8.
    wb_write(A_RISE, 32'h01);
    wb_write(A_DEB, 32'h0);
    gpio = 8'h01;
    idle(7);
    check("rise_intr_early", 32'(intr), 32'd0);
    idle(1);
    check("rise_intr", 32'(intr), 32'd1);
    rd_check("rise_pend", A_PEND, 32'h01);
    rd_check("rise_evc", A_EVC, 32'd1);
    rd_check("rise_in", A_IN, 32'h01);
    wb_write(A_PEND, 32'h01);
    rd_check("w1c_pend", A_PEND, 32'h0);
    check("w1c_intr", 32'(intr), 32'd0);

    // Glitch rejection: 2-cycle pulse never reaches 3 agreeing ticks.
    gpio = 8'h00;
    idle(20);
    gpio = 8'h01;
    idle(2);
    gpio = 8'h00;
    idle(20);
    rd_check("glitch_in", A_IN, 32'h0);
    rd_check("glitch_pend", A_PEND, 32'h0);
    rd_check("glitch_evc", A_EVC, 32'd1);

    // Toggle train at PRESCALE=99, both edges then rise only.
    wb_write(A_EVC, 32'h0);
    wb_write(A_FALL, 32'h01);
    wb_write(A_DEB, 32'd99);
    for (int i = 0; i < 10; i++) begin
      gpio[0] = ~gpio[0];
      idle(2000);
    end
    rd_check("train_evc10", A_EVC, 32'd10);
    rd_check("train_in", A_IN, 32'h0);
    wb_write(A_FALL, 32'h0);
    wb_write(A_EVC, 32'h0);
    for (int i = 0; i < 10; i++) begin
      gpio[0] = ~gpio[0];
      idle(2000);
    end
    rd_check("train_evc5", A_EVC, 32'd5);
    wb_write(A_PEND, 32'hFF);

    // W1C colliding with a new event: set wins.
    wb_write(A_FALL, 32'h01);
    wb_write(A_DEB, 32'h0);
    gpio = 8'h01;
    idle(20);
    rd_check("coll_pre", A_PEND, 32'h01);
    gpio = 8'h00;
    idle(6);
    wb_write(A_PEND, 32'h01);
    idle(5);
    rd_check("coll_pend", A_PEND, 32'h01);

    // EVCOUNT write colliding with an event: write wins.
    gpio = 8'h01;
    idle(6);
    wb_write(A_EVC, 32'h0005);
    idle(10);
    rd_check("evc_coll", A_EVC, 32'h0005);

    // EVCOUNT wrap.
    wb_write(A_EVC, 32'h0000FFFF);
    gpio = 8'h00;
    idle(20);
    rd_check("evc_wrap", A_EVC, 32'h0);
    wb_write(A_PEND, 32'hFF);

    // Back-to-back strobe: ack every other cycle; 0x1C reads 0.
    rd_check("pre_rise", A_RISE, 32'h01);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_R1C;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("b2b_ack", 32'(wb_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) check("b2b_dat", wb_dat_r, 32'h0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    idle(2);
    rd_check("r18", A_R18, 32'h0);
    wb_write(A_IN, 32'hFF);
    rd_check("in_ro", A_IN, 32'h0);
    wb_write(A_RISE, 32'hFFFF_FFFF);
    rd_check("rise_upper", A_RISE, 32'h0000_00FF);
    wb_write(A_DEB, 32'hFFFF_FFFF);
    rd_check("deb_upper", A_DEB, 32'h0000_FFFF);

    // Mid-operation reset with input held high.
    wb_write(A_DEB, 32'h0);
    gpio = 8'h01;
    idle(20);
    check("pre_rst_intr", 32'(intr), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_intr", 32'(intr), 32'd0);
    check("mid_rst_ack", 32'(wb_ack), 32'd0);
    check("mid_rst_dat", wb_dat_r, 32'h0);
    idle(3);
    rst = 1'b1;
    idle(1);
    rd_check("post_rst_deb", A_DEB, 32'd99);
    rd_check("post_rst_pend0", A_PEND, 32'h0);
    wb_write(A_RISE, 32'h01);
    idle(600);
    rd_check("post_rst_in", A_IN, 32'h01);
    rd_check("post_rst_pend", A_PEND, 32'h01);
    check("post_rst_intr", 32'(intr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_edge_capture.md
Name: gpio_edge_capture

Overview:
Wishbone-slave GPIO input block for the LM32 system, and the reading end of the gpio_io pins that external logic or the bench drives.
- Synchronises and debounces each input bit.
- Detects rising and falling edges under per-bit enable masks.
- Latches events into a write-1-to-clear pending register, counts them, and raises an interrupt to the CPU.
- Sits on the peripheral Wishbone bus next to the UART and timer.

Parameters:
WIDTH, 8, number of GPIO input bits (1..32)
DEB_COUNT, 3, consecutive agreeing sample ticks required to change a debounced bit (1..15)
PRESCALE_RESET, 99, reset value of the DEBOUNCE prescaler register (tick every PRESCALE+1 clocks)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
gpio_i  in  WIDTH  raw asynchronous GPIO inputs
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  32  byte address; decode uses bits [4:2]
wb_sel_i  in  4  byte selects; only full-word accesses are supported, partial selects are treated as full
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
wb_ack_o  out  1  single-cycle acknowledge
intr_o  out  1  interrupt, high while any PENDING bit is set

Behaviour:
- Reset: rst low asynchronously clears every flop.
  - All outputs reset to 0, including wb_ack_o, wb_dat_o and intr_o.
  - Synchroniser and debounced state reset to 0; RISE_EN, FALL_EN, PENDING and EVCOUNT reset to 0.
  - PRESCALE resets to PRESCALE_RESET. The prescaler counter resets to 0.
- Synchroniser: 2-flop chain per bit, 2 cycles of latency.
- Prescaler:
  - The counter counts 0..PRESCALE, and a one-cycle tick is emitted when it equals PRESCALE, after which it wraps to 0.
  - With PRESCALE=0, tick is asserted every cycle.
  - A write to DEBOUNCE loads the new value and resets the counter to 0.
- Debounce, per bit, 4-bit agreement counter:
  - On a tick where the synced bit equals the debounced bit, the counter clears.
  - On a tick where they differ, the counter increments.
  - When the counter reaches DEB_COUNT, the debounced bit toggles and the counter clears in the same cycle.
  - Between ticks the counter holds.
- Edge detect: registered compare of the debounced value against its previous value.
  - rise[i] = new 1 & old 0; fall[i] = new 0 & old 1.
  - ev[i] = (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- PENDING:
  - Next value = (PENDING & ~W1C mask) | ev.
  - When a set and a clear of the same bit occur in the same cycle, the set wins.
- EVCOUNT: 16-bit counter.
  - Increments by 1 in any cycle where |ev, regardless of how many bits fire.
  - Wraps 0xFFFF -> 0x0000.
  - A write loads wb_dat_i[15:0]; the write wins and an event in that cycle is not counted.
- intr_o: registered |PENDING, so it goes high 1 cycle after PENDING sets.
- Register map (word offset -> register):
  - 0x00 IN: debounced level, RO; writes are ignored.
  - 0x04 RISE_EN: RW.
  - 0x08 FALL_EN: RW.
  - 0x0C PENDING: read, write-1-to-clear.
  - 0x10 EVCOUNT: RW, value in [15:0].
  - 0x14 DEBOUNCE: RW, 16-bit value in [15:0].
  - 0x18 and 0x1C read 0 and ignore writes.
  - Unused upper bits read 0.
- Wishbone handshake:
  - When cyc&stb and ack=0, the write takes effect and read data is captured; ack=1 on the next cycle, for exactly 1 cycle.
  - ack is low for at least 1 cycle between accesses, so each access costs 2 cycles.
  - wb_dat_o holds its last value when ack is low.
- Latency: from a gpio_i change to PENDING set is 2 sync cycles + DEB_COUNT ticks + 1 edge cycle + 1 register cycle.
- Mid-operation reset clears everything immediately. A gpio_i level held high through reset is reported as a rising edge once debounced after reset release.

Decomposition:
- Shared package holds the register offset constants (GPIO_IN, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_PENDING, GPIO_EVCOUNT, GPIO_DEBOUNCE) and the width of the 4-bit debounce counter.
- One sub-module, gpio_debounce_bit: synchroniser, agreement counter and debounced flop for a single bit, instantiated WIDTH times sharing the tick.

Test Plan:
- Reset: rst=0 for 80 ns, then read all registers -> IN=0, RISE_EN=0, FALL_EN=0, PENDING=0, EVCOUNT=0, DEBOUNCE=99, intr_o=0.
- Rising edge: set RISE_EN=0x01, PRESCALE=0, then drive gpio_i=0x01 -> PENDING=0x01 exactly 2+3+1+1 cycles after the change, intr_o high 1 cycle later, EVCOUNT=1; write 0x01 to PENDING -> PENDING=0, intr_o=0.
- Glitch rejection: PRESCALE=0, drive a 2-cycle pulse of 0x01 -> IN stays 0, PENDING stays 0, EVCOUNT unchanged.
- Toggle train: RISE_EN=FALL_EN=0x01, PRESCALE=99, toggle bit 0 every 2000 cycles 10 times -> EVCOUNT=10 and IN ends at 0; with FALL_EN=0 instead -> EVCOUNT=5.
- Simultaneous events:
  - W1C of bit 0 in the same cycle as a new bit-0 event -> PENDING bit 0 remains 1.
  - EVCOUNT write of 0x0005 in an event cycle -> EVCOUNT reads 0x0005.
  - EVCOUNT=0xFFFF plus one event -> EVCOUNT reads 0x0000.
- Bus handshake: back-to-back stb held high -> ack pulses every other cycle; a read of offset 0x1C returns 0.
